// File: rtl/stage_sequencer_if.sv
// -----------------------------------------------------------------------------
// stage_sequencer_if
//
// Purpose : Bundles the control handshake between a stage sequencer and its
//           surrounding environment (requester plus the datapath state machine).
//
// Parameters
//   STATE_LEN  width of the state code d
//
// Signals
//   start       requester -> sequencer   one-cycle request to begin a sequence
//   hold        requester -> sequencer   pause, forces run low while high
//   loops[7:0]  requester -> sequencer   passes over all stages (0 means 1)
//   stage_done  datapath  -> sequencer   one-cycle completion of active stage
//   run         sequencer -> datapath    run enable
//   set         sequencer -> datapath    load strobe for d
//   d           sequencer -> datapath    state code (0 = IDLE, stage k = k+1)
//   busy        sequencer -> requester   high whenever not idle
//   pass_cnt    sequencer -> requester   index of the current pass
//   finish      sequencer -> requester   one-cycle pulse at end of last pass
//   error       sequencer -> requester   sticky watchdog flag
//
// Modports
//   master  environment side (drives requests, observes status)
//   slave   sequencer side
// -----------------------------------------------------------------------------
interface stage_sequencer_if #(
   parameter int STATE_LEN = 3
);
   logic                 start;
   logic                 hold;
   logic [7:0]           loops;
   logic                 stage_done;
   logic                 run;
   logic                 set;
   logic [STATE_LEN-1:0] d;
   logic                 busy;
   logic [7:0]           pass_cnt;
   logic                 finish;
   logic                 error;

   modport master (
      output start, hold, loops, stage_done,
      input  run, set, d, busy, pass_cnt, finish, error
   );

   modport slave (
      input  start, hold, loops, stage_done,
      output run, set, d, busy, pass_cnt, finish, error
   );
endinterface

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Purpose : Steps a downstream state machine through NUM_STAGES datapath
//           stages, repeated for a requested number of passes. Each stage is
//           entered with a one-cycle load strobe (set) carrying the stage code
//           on d, then enabled with run until the stage reports stage_done.
//
// Parameters
//   STATE_LEN   width of the state code d
//   NUM_STAGES  stages per pass (1 .. 2**STATE_LEN-1)
//   TIMEOUT     per-stage watchdog limit in run cycles
//
// Ports
//   clk   in   single clock, rising edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of stage_sequencer_if (start, hold, loops, stage_done
//         in; run, set, d, busy, pass_cnt, finish, error out)
//
// Build option
//   STAGE_SEQUENCER_TIMEOUT_EN  when defined, a per-stage watchdog counts run
//   cycles in EXEC; on reaching TIMEOUT it raises the sticky error flag and
//   abandons the sequence (back to IDLE, no finish pulse). When undefined the
//   watchdog does not exist, error is tied low and EXEC waits indefinitely.
//
// All outputs are registered: the next-cycle value of every output is derived
// from the next state, so outputs always describe the state being entered.
// -----------------------------------------------------------------------------
module stage_sequencer #(
   parameter int STATE_LEN  = 3,
   parameter int NUM_STAGES = 5,
   parameter int TIMEOUT    = 1024
) (
   input logic              clk,
   input logic              rst,
   stage_sequencer_if.slave bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_EXEC = 3'd2;
   localparam logic [2:0] S_ADV  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [STATE_LEN-1:0] LAST_IDX = STATE_LEN'(NUM_STAGES - 1);
   localparam logic [STATE_LEN-1:0] ONE_IDX  = STATE_LEN'(1);

   // Reject configurations the stage code cannot represent.
   if (NUM_STAGES < 1 || NUM_STAGES > (2**STATE_LEN) - 1 || TIMEOUT < 1) begin : g_param_chk
      $error("stage_sequencer: illegal NUM_STAGES/STATE_LEN/TIMEOUT combination");
   end

   logic [2:0]           state_q,  state_n;
   logic [STATE_LEN-1:0] idx_q,    idx_n;
   logic [7:0]           pass_q,   pass_n;
   logic [7:0]           loops_q,  loops_n;
   logic                 run_q,    run_n;
   logic                 set_q,    set_n;
   logic [STATE_LEN-1:0] d_q,      d_n;
   logic                 busy_q,   busy_n;
   logic                 finish_q, finish_n;

   logic                 last_stage;
   logic                 last_pass;
   logic                 wd_expire;

   assign last_stage = (idx_q == LAST_IDX);
   assign last_pass  = (pass_q == (loops_q - 8'd1));

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
`ifdef STAGE_SEQUENCER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] wdog_q;
   logic            error_q;

   // Expiry is evaluated during the run cycle that would be number TIMEOUT,
   // so the abort edge closes exactly TIMEOUT run cycles.
   assign wd_expire = (state_q == S_EXEC) && run_q && (wdog_q == WD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_q <= '0;
      end else if (state_q == S_LOAD) begin
         wdog_q <= '0;
      end else if (state_q == S_EXEC && run_q && !wd_expire) begin
         wdog_q <= wdog_q + 1'b1;
      end
   end

   // The only EXEC -> IDLE transition is a watchdog abort; the only
   // IDLE -> LOAD transition is an accepted start, which clears the flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         error_q <= 1'b0;
      end else if (state_q == S_IDLE && state_n == S_LOAD) begin
         error_q <= 1'b0;
      end else if (state_q == S_EXEC && state_n == S_IDLE) begin
         error_q <= 1'b1;
      end
   end

   assign bus.error = error_q;
`else
   assign wd_expire = 1'b0;
   assign bus.error = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_n  = state_q;
      idx_n    = idx_q;
      pass_n   = pass_q;
      loops_n  = loops_q;
      run_n    = 1'b0;
      set_n    = 1'b0;
      d_n      = d_q;
      finish_n = 1'b0;

      case (state_q)
         S_IDLE: begin
            d_n = '0;
            if (bus.start) begin
               loops_n = (bus.loops == 8'd0) ? 8'd1 : bus.loops;
               idx_n   = '0;
               pass_n  = 8'd0;
               state_n = S_LOAD;
               set_n   = 1'b1;
               d_n     = ONE_IDX;
            end
         end

         S_LOAD: begin
            state_n = S_EXEC;
            run_n   = ~bus.hold;
         end

         S_EXEC: begin
            // stage_done wins over hold and over a coincident watchdog expiry.
            if (bus.stage_done) begin
               state_n = S_ADV;
            end else if (wd_expire) begin
               state_n = S_IDLE;
               d_n     = '0;
            end else begin
               run_n = ~bus.hold;
            end
         end

         S_ADV: begin
            if (last_stage && last_pass) begin
               state_n  = S_DONE;
               finish_n = 1'b1;
               d_n      = '0;
            end else begin
               if (last_stage) begin
                  idx_n  = '0;
                  pass_n = pass_q + 8'd1;
               end else begin
                  idx_n = idx_q + ONE_IDX;
               end
               state_n = S_LOAD;
               set_n   = 1'b1;
               d_n     = idx_n + ONE_IDX;
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
            d_n     = '0;
         end
      endcase

      busy_n = (state_n != S_IDLE);
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         pass_q   <= 8'd0;
         loops_q  <= 8'd1;
         run_q    <= 1'b0;
         set_q    <= 1'b0;
         d_q      <= '0;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         state_q  <= state_n;
         idx_q    <= idx_n;
         pass_q   <= pass_n;
         loops_q  <= loops_n;
         run_q    <= run_n;
         set_q    <= set_n;
         d_q      <= d_n;
         busy_q   <= busy_n;
         finish_q <= finish_n;
      end
   end

   assign bus.run      = run_q;
   assign bus.set      = set_q;
   assign bus.d        = d_q;
   assign bus.busy     = busy_q;
   assign bus.pass_cnt = pass_q;
   assign bus.finish   = finish_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// Directed bench for stage_sequencer (NUM_STAGES=3, TIMEOUT=16). Stimulus
// pushes the expected set/finish events into a queue; an independent monitor
// pops and compares whenever the sequencer emits set or finish. Cycle-exact
// properties (reset state, latency, hold, abort) are checked inline.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;
   localparam int STATE_LEN  = 3;
   localparam int NUM_STAGES = 3;
   localparam int TIMEOUT    = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stage_sequencer_if #(.STATE_LEN(STATE_LEN)) bus ();

   stage_sequencer #(
      .STATE_LEN (STATE_LEN),
      .NUM_STAGES(NUM_STAGES),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      bit         is_fin;
      logic [2:0] d;
      logic [7:0] pass;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_set(input logic [2:0] d, input logic [7:0] p);
      ev_t e;
      e.is_fin = 1'b0; e.d = d; e.pass = p;
      exp_q.push_back(e);
   endtask

   task automatic push_fin(input logic [7:0] p);
      ev_t e;
      e.is_fin = 1'b1; e.d = 3'd0; e.pass = p;
      exp_q.push_back(e);
   endtask

   task automatic start_seq(input logic [7:0] l);
      bus.loops = l;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_run(input string name);
      int i = 0;
      while (!bus.run && i < 100) begin
         tick();
         i++;
      end
      check(name, bus.run, 1);
   endtask

   // Complete the active stage: stage_done four cycles after run rises.
   task automatic serve();
      wait_run("run_rise");
      tick(4);
      bus.stage_done = 1'b1;
      tick();
      bus.stage_done = 1'b0;
   endtask

   task automatic wait_finish();
      int i = 0;
      while (!bus.finish && i < 100) begin
         tick();
         i++;
      end
      check("finish_seen", bus.finish, 1);
      check("busy_in_done", bus.busy, 1);
      tick();
      check("busy_after_finish", bus.busy, 0);
      check("finish_one_cycle", bus.finish, 0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (bus.set || bus.finish) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_event", exp_q.size(), 1);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("sb_kind_finish", bus.finish, e.is_fin);
            check("sb_d", bus.d, e.d);
            check("sb_pass_cnt", bus.pass_cnt, e.pass);
         end
         if (bus.set) check("set_run_exclusive", bus.run, 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "stopped");
   end

   initial begin
      rst            = 1'b1;
      bus.start      = 1'b1;
      bus.hold       = 1'b0;
      bus.loops      = 8'd1;
      bus.stage_done = 1'b0;

      // Reset with start asserted
      tick(2);
      rst       = 1'b0;
      bus.start = 1'b0;
      check("rst_run", bus.run, 0);
      check("rst_set", bus.set, 0);
      check("rst_d", bus.d, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_pass", bus.pass_cnt, 0);
      check("rst_finish", bus.finish, 0);
      check("rst_error", bus.error, 0);
      tick(2);
      check("post_rst_busy", bus.busy, 0);

      // stage_done while idle
      bus.stage_done = 1'b1;
      tick();
      bus.stage_done = 1'b0;
      tick(2);
      check("idle_done_busy", bus.busy, 0);
      check("idle_done_d", bus.d, 0);

      // Basic sequence, one pass
      push_set(3'd1, 8'd0); push_set(3'd2, 8'd0); push_set(3'd3, 8'd0); push_fin(8'd0);
      start_seq(8'd1);
      check("lat_set", bus.set, 1);
      check("lat_set_run", bus.run, 0);
      check("lat_busy", bus.busy, 1);
      tick();
      check("lat_run", bus.run, 1);
      check("lat_set_low", bus.set, 0);
      repeat (NUM_STAGES) serve();
      wait_finish();
      check("basic_drain", exp_q.size(), 0);

      // Two passes
      for (int p = 0; p < 2; p++)
         for (int s = 1; s <= NUM_STAGES; s++) push_set(3'(s), 8'(p));
      push_fin(8'd1);
      start_seq(8'd2);
      repeat (2 * NUM_STAGES) serve();
      wait_finish();
      check("multi_drain", exp_q.size(), 0);

      // Hold during EXEC, spurious start mid-sequence
      push_set(3'd1, 8'd0); push_set(3'd2, 8'd0); push_set(3'd3, 8'd0); push_fin(8'd0);
      start_seq(8'd1);
      wait_run("hold_run");
      bus.hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.start = (i == 1);
         bus.loops = 8'd5;
         tick();
         check("hold_run_low", bus.run, 0);
         check("hold_d", bus.d, 1);
      end
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      tick();
      check("hold_release_run", bus.run, 1);
      repeat (NUM_STAGES) serve();
      wait_finish();
      check("hold_drain", exp_q.size(), 0);

      // Reset mid-EXEC on stage 2, then restart with loops=0 (one pass)
      push_set(3'd1, 8'd0); push_set(3'd2, 8'd0);
      start_seq(8'd1);
      serve();
      wait_run("s2_run");
      check("s2_d", bus.d, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", bus.busy, 0);
      check("midrst_run", bus.run, 0);
      check("midrst_d", bus.d, 0);
      check("midrst_pass", bus.pass_cnt, 0);
      check("midrst_drain", exp_q.size(), 0);
      push_set(3'd1, 8'd0); push_set(3'd2, 8'd0); push_set(3'd3, 8'd0); push_fin(8'd0);
      start_seq(8'd0);
      check("restart_d", bus.d, 1);
      check("restart_pass", bus.pass_cnt, 0);
      repeat (NUM_STAGES) serve();
      wait_finish();
      check("restart_drain", exp_q.size(), 0);

      // Stage that never completes
      push_set(3'd1, 8'd0);
      start_seq(8'd1);
      wait_run("to_run");
`ifdef STAGE_SEQUENCER_TIMEOUT_EN
      tick(TIMEOUT - 1);
      check("to_before_busy", bus.busy, 1);
      check("to_before_error", bus.error, 0);
      tick();
      check("to_error", bus.error, 1);
      check("to_busy", bus.busy, 0);
      check("to_run_low", bus.run, 0);
      check("to_no_finish", bus.finish, 0);
      tick(2);
      check("to_error_sticky", bus.error, 1);
      check("to_drain", exp_q.size(), 0);
      push_set(3'd1, 8'd0); push_set(3'd2, 8'd0); push_set(3'd3, 8'd0); push_fin(8'd0);
      start_seq(8'd1);
      check("to_error_cleared", bus.error, 0);
      repeat (NUM_STAGES) serve();
      wait_finish();
`else
      tick(TIMEOUT + 4);
      check("nowd_busy", bus.busy, 1);
      check("nowd_run", bus.run, 1);
      check("nowd_d", bus.d, 1);
      check("nowd_error", bus.error, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("nowd_rst_busy", bus.busy, 0);
`endif
      tick(2);
      check("final_drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter STATE_LEN, default 3, SHALL set the width of the state code driven to the state machine.
REQ-002 Parameter NUM_STAGES, default 5, SHALL set the number of datapath stages per pass (1..2^STATE_LEN-1).
REQ-003 Parameter TIMEOUT, default 1024, SHALL set the per-stage watchdog limit in run cycles.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 start  in  1  one-cycle request to begin a sequence.
REQ-007 hold  in  1  pause; while high, run is forced low.
REQ-008 loops  in  8  number of passes over all stages; 0 is treated as 1.
REQ-009 stage_done  in  1  one-cycle completion pulse from the active datapath stage.
REQ-010 run  out  1  run enable to the state machine.
REQ-011 set  out  1  load strobe to the state machine.
REQ-012 d  out  STATE_LEN  state code to load; 0 = IDLE, stage k = k+1.
REQ-013 busy  out  1  high in every FSM state except IDLE.
REQ-014 pass_cnt  out  8  index of the current pass, from 0.
REQ-015 finish  out  1  one-cycle pulse when the last pass completes.
REQ-016 error  out  1  sticky watchdog flag; constant 0 when the watchdog is compiled out.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, EXEC, ADV and DONE.
REQ-018 IDLE: run=0, set=0, d=0; start=1 SHALL latch loops, clear stage index and pass_cnt, clear error, and go to LOAD.
REQ-019 LOAD SHALL last exactly one cycle with set=1, run=0, d=index+1, then go to EXEC.
REQ-020 EXEC: set=0, d held, run=~hold; stage_done=1 SHALL go to ADV, whether or not hold is high.
REQ-021 ADV SHALL last one cycle with run=0 and make exactly one transition:
- last stage and last pass: go to DONE;
- last stage only: index=0, pass_cnt+1, go to LOAD;
- otherwise: index+1, go to LOAD.
REQ-022 DONE SHALL last one cycle with finish=1, d=0, run=0, then go to IDLE.
REQ-023 Latency: start accepted at edge t SHALL give set=1 in cycle t+1 and run=1 (hold low) in cycle t+2.
REQ-024 start SHALL be ignored outside IDLE, and stage_done outside EXEC.
REQ-025 Outputs SHALL be registered; set and run SHALL never both be 1.

Reset
REQ-026 rst=1 SHALL force IDLE, run=0, set=0, d=0, busy=0, pass_cnt=0, finish=0, error=0, stage index 0, watchdog 0 at the next edge.
REQ-027 rst SHALL take priority over start, stage_done and any in-progress sequence, including mid-EXEC.

Configuration
REQ-028 With macro STAGE_SEQUENCER_TIMEOUT_EN defined, a watchdog SHALL behave as follows:
- it counts EXEC cycles with run=1 and clears on each LOAD;
- on reaching TIMEOUT it sets error=1 and sends the FSM to IDLE with no finish pulse.
REQ-029 Without STAGE_SEQUENCER_TIMEOUT_EN, no watchdog logic SHALL exist, error SHALL be tied to 0, and EXEC SHALL wait indefinitely.

Verification (NUM_STAGES=3, TIMEOUT=16 unless stated)
REQ-030 Reset: rst=1 for 2 cycles, start=1 during reset -> all outputs 0 and busy=0 after release.
REQ-031 Basic sequence, loops=1, stage_done 4 cycles after each run rise -> d sequence 1,2,3,0; finish pulses once; busy falls the cycle after finish.
REQ-032 Multi-pass, loops=2 -> pass_cnt goes 0 then 1; six set pulses; finish only after the second stage-3 done.
REQ-033 Hold and spurious inputs:
- hold=1 for 5 cycles in EXEC -> run=0 for those cycles, d unchanged;
- start pulsed mid-sequence -> no effect;
- stage_done in IDLE -> no effect.
REQ-034 Reset mid-operation: rst=1 while EXEC on stage 2 -> IDLE next cycle; a new start restarts at d=1 with pass_cnt=0.
REQ-035 Timeout (macro defined): no stage_done for 16 run cycles -> error=1, busy=0, no finish; the next start clears error; with the macro undefined, the same stimulus leaves the FSM in EXEC.
